// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, fixed latency.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      Idle,
      Iter,
      Fix
   } state_t;

   state_t               state;
   logic [CntW-1:0]      cnt;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     opB;
   logic                 isDiv;
   logic                 negLo;
   logic                 negHi;
   logic                 divZero;

   logic                 signedOp;
   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;
   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulNext;
   logic [WIDTH:0]       divShift;
   logic [WIDTH-1:0]     divDiff;
   logic                 divGe;
   logic [2*WIDTH-1:0]   divNext;
   logic [2*WIDTH-1:0]   stepNext;
   logic [2*WIDTH-1:0]   prodNeg;
   logic [WIDTH-1:0]     quoFix;
   logic [WIDTH-1:0]     remFix;

   // Operand conditioning: magnitudes for signed ops, raw values for unsigned ops.
   always_comb begin
      signedOp = ~op[0];
      magA     = (signedOp && srca[WIDTH-1]) ? -srca : srca;
      magB     = (signedOp && srcb[WIDTH-1]) ? -srcb : srcb;
   end

   // prod holds {partial/remainder, multiplier/dividend} for both operations.
   always_comb begin
      mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opB} : '0);
      mulNext  = {mulSum, prod[WIDTH-1:1]};
      divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      divGe    = divShift >= {1'b0, opB};
      divDiff  = divShift[WIDTH-1:0] - opB;
      divNext  = divGe ? {divDiff, prod[WIDTH-2:0], 1'b1}
                       : {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      stepNext = isDiv ? divNext : mulNext;
   end

   always_comb begin
      prodNeg = -prod;
      quoFix  = negLo ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      remFix  = negHi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= Idle;
         cnt         <= '0;
         prod        <= '0;
         opB         <= '0;
         isDiv       <= 1'b0;
         negLo       <= 1'b0;
         negHi       <= 1'b0;
         divZero     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            Idle: begin
               if (start) begin
                  isDiv       <= op[1];
                  prod        <= {{WIDTH{1'b0}}, magA};
                  opB         <= magB;
                  divZero     <= (srcb == '0);
                  // A zero divisor leaves quotient all-ones and remainder = dividend; skip fixup.
                  negLo       <= signedOp && (srca[WIDTH-1] ^ srcb[WIDTH-1])
                                 && !(op[1] && srcb == '0);
                  negHi       <= signedOp && srca[WIDTH-1] && op[1] && (srcb != '0);
                  cnt         <= '0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  state       <= Iter;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            Iter: begin
               prod <= stepNext;
               cnt  <= cnt + 1'b1;
               if (cnt == LastCnt) state <= Fix;
            end
            Fix: begin
               if (isDiv) begin
                  hi <= remFix;
                  lo <= quoFix;
               end else begin
                  {hi, lo} <= negLo ? prodNeg : prod;
               end
               div_by_zero <= isDiv && divZero;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= Idle;
            end
            default: state <= Idle;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of operations with hand-computed
// results, plus sequences for busy interference, mid-op reset and back-to-back starts.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int nChecks = 0;
   int nFail   = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .srca        (srca),
      .srcb        (srcb),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      logic        expDz;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle 1 (the cycle after the start edge).
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      srca  = a;
      srcb  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Polls done each negedge from cycle startCyc; busy must be high until the done cycle.
   task automatic waitDone(input int startCyc, output int lat, output logic busyOk);
      lat    = startCyc;
      busyOk = 1'b1;
      while (!done && lat < 60) begin
         if (!busy) busyOk = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy) busyOk = 1'b0;
   endtask

   initial begin
      int   lat;
      logic busyOk;
      int   pulses;

      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
      vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[6]  = '{2'b00, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1'b0};
      vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      vecs[10] = '{2'b01, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};
      vecs[11] = '{2'b10, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};

      rst   = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      srca  = '0;
      srcb  = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_dz",   32'(div_by_zero), 32'd0);
      check("reset_hi",   hi, 32'd0);
      check("reset_lo",   lo, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         waitDone(1, lat, busyOk);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
         check($sformatf("vec%0d_busy", i), 32'(busyOk), 32'd1);
         check($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
         check($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].expDz));
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      end

      // mthi/mtlo together, then busy interference: start+hi_we at cycle 5 is ignored.
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h00001234;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mthi_both", hi, 32'h00001234);
      check("mtlo_both", lo, 32'h00001234);
      launch(2'b00, 32'd2, 32'd3);
      repeat (4) @(negedge clk);
      start = 1'b1;
      op    = 2'b11;
      hi_we = 1'b1;
      wdata = 32'h0000DEAD;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      check("busy_hi_hold", hi, 32'h00001234);
      waitDone(6, lat, busyOk);
      check("intf_latency", 32'(lat), 32'd34);
      check("intf_hi", hi, 32'd0);
      check("intf_lo", lo, 32'd6);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("intf_extra_done", 32'(pulses), 32'd0);

      // Asynchronous reset mid-operation.
      launch(2'b01, 32'h00001234, 32'h00000010);
      repeat (9) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi",   hi, 32'd0);
      check("arst_lo",   lo, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("arst_no_done", 32'(pulses), 32'd0);
      check("arst_lo_hold", lo, 32'd0);
      lo_we = 1'b1;
      wdata = 32'h0000CAFE;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo_after_rst", lo, 32'h0000CAFE);
      check("mtlo_hi_untouched", hi, 32'd0);

      // Back-to-back: start (with a dropped lo_we) issued in the done cycle of divu 7/0.
      @(negedge clk);
      launch(2'b11, 32'd7, 32'd0);
      waitDone(1, lat, busyOk);
      check("b2b_first_dz", 32'(div_by_zero), 32'd1);
      lo_we = 1'b1;
      wdata = 32'h0000BEEF;
      launch(2'b00, 32'h7FFFFFFF, 32'h00000002);
      lo_we = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_lo_dropped", lo, 32'hFFFFFFFF);
      check("b2b_dz_cleared", 32'(div_by_zero), 32'd0);
      waitDone(1, lat, busyOk);
      check("b2b_latency", 32'(lat), 32'd34);
      check("b2b_busy_window", 32'(busyOk), 32'd1);
      check("b2b_hi", hi, 32'd0);
      check("b2b_lo", lo, 32'hFFFFFFFE);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers for the multicycle MIPS core.
- Sits beside the ALU stage. Operands come from the RF read ports (A/B). Results are consumed by the Mem2Reg write-back mux (mfhi/mflo) and the Ctrl FSM, which stalls on busy.
- Supports mult, multu, div, divu, mthi, mtlo.
- Radix-2 shift-add multiply and restoring divide; one bit per cycle.

Parameters:
WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset; asynchronous, active-low.
start  input  1  start request; sampled only in IDLE.
op  input  2  00 mult, 01 multu, 10 div, 11 divu; latched with start.
srca  input  WIDTH  rs operand (multiplicand / dividend).
srcb  input  WIDTH  rt operand (multiplier / divisor).
hi_we  input  1  mthi write enable.
lo_we  input  1  mtlo write enable.
wdata  input  WIDTH  mthi/mtlo data.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; HI/LO updated.
div_by_zero  output  1  valid with done; divisor was 0 on div/divu.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Any in-flight operation is aborted with no partial HI/LO update.
- States: IDLE, ITER, FIX.
  - IDLE -> ITER on edge E0 with start=1.
    - At E0: latch op; latch |srca|, |srcb| for signed ops, raw values for unsigned ops; record result signs; counter=0; busy=1 after E0.
  - ITER: one iteration per edge, E1..E32; counter increments each edge. After E32 (counter==WIDTH-1 at that edge) -> FIX.
  - FIX -> IDLE at E33:
    - Apply sign fixup.
    - Write hi/lo.
    - done=1 and busy=0 for the cycle after E33.
    - div_by_zero valid in that same cycle.
  - Latency: start edge to done-visible = 34 cycles. Fixed; no early termination.
- Multiply:
  - {hi,lo} = full 2*WIDTH-bit product.
  - Signed: negate the 64-bit magnitude product iff the operand signs differ.
- Divide:
  - lo = quotient, truncated toward zero.
  - hi = remainder, carrying the sign of the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0; no flag.
  - Divisor 0: lo=0xFFFFFFFF, hi=srca (as latched, unsigned value); div_by_zero=1 with done. Still takes the full 34 cycles.
- mthi/mtlo:
  - Accepted only in IDLE with start=0; write takes effect at the next edge.
  - hi_we and lo_we may both be asserted; both registers take wdata.
- Conflicts:
  - start=1 in IDLE together with hi_we/lo_we: start wins, the write is dropped.
  - start, hi_we, lo_we while busy: ignored; HI/LO keep prior values until FIX.
  - start asserted in the done cycle (state IDLE): accepted; the next done arrives 34 cycles later.
- hi/lo:
  - Are registers; never show intermediate iteration values.
  - Hold between operations.
- div_by_zero:
  - Cleared on the next accepted start.
  - Otherwise holds.

Test Plan:
1. multu srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> done on the 34th cycle after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly cycles 1..33.
2. mult -3 x 5 (0xFFFFFFFD, 0x00000005) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
3. divu 7/0 -> lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1 with done. Then divu 100/7 -> lo=14, hi=2, div_by_zero=0.
4. Busy interference:
   - Start mult 2x3, then at cycle 5 pulse start (op=divu) plus hi_we with wdata=0xDEAD -> both ignored; final hi=0, lo=6; exactly one done pulse.
5. Reset mid-operation:
   - Start multu 0x1234x0x10, drop rst at cycle 10 asynchronously (between edges) -> busy, hi, lo fall to 0 immediately; no done pulse.
   - After release, mtlo 0xCAFE -> lo=0xCAFE next cycle.
6. Back-to-back:
   - Assert start in the done cycle with mult 0x7FFFFFFF x 2 -> accepted; hi=0, lo=0xFFFFFFFE; second done 34 cycles later.
   - start+lo_we in the same IDLE cycle -> write dropped.
